ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline register for the OpenMIPS core.
- Extends the plain pass-through register with:
  - HI/LO write channel
  - per-stage stall vector and flush
  - bubble insertion
  - carry-back of multi-cycle EX state (accumulate temp and cycle counter)
  - saturating bubble-cycle performance counter
- Sits between the ex and mem stages; ctrl drives stall/flush.

Parameters:
- DATA_W, 32, width of GPR/HI/LO data.
- REG_AW, 5, GPR address width.
- CNT_W, 2, multi-cycle op counter width.
- STALL_W, 6, width of stall vector from ctrl.
- EX_IDX, 3, stall bit index of EX stage.
- MEM_IDX, 4, stall bit index of MEM stage.
- PERF_W, 16, bubble counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- stall  in  STALL_W  per-stage stall vector from ctrl.
- flush  in  1  pipeline flush (exception/eret).
- ex_valid  in  1  EX holds a real instruction.
- ex_wd  in  REG_AW  GPR write address.
- ex_wreg  in  1  GPR write enable.
- ex_wdata  in  DATA_W  GPR write data.
- ex_whilo  in  1  HI/LO write enable.
- ex_hi  in  DATA_W  HI write data.
- ex_lo  in  DATA_W  LO write data.
- hilo_i  in  2*DATA_W  multi-cycle temp from EX.
- cnt_i  in  CNT_W  multi-cycle counter from EX.
- mem_valid  out  1  registered valid.
- mem_wd  out  REG_AW  registered GPR address.
- mem_wreg  out  1  registered GPR write enable.
- mem_wdata  out  DATA_W  registered GPR write data.
- mem_whilo  out  1  registered HI/LO write enable.
- mem_hi  out  DATA_W  registered HI data.
- mem_lo  out  DATA_W  registered LO data.
- hilo_o  out  2*DATA_W  temp fed back to EX.
- cnt_o  out  CNT_W  counter fed back to EX.
- bubble_cnt  out  PERF_W  saturating count of inserted bubbles.

Behaviour:
- Reset (rst==0, asynchronous, any time): all outputs 0.
  - mem_wd = NOPRegAddr (0); write enables = WriteDisable.
  - Takes effect immediately, not at the next edge.
  - First capture occurs on the first rising clk after rst returns to 1.
- Latency: one cycle, EX to MEM.
- Per rising edge, modes in strict priority order:
  1. FLUSH (flush==1): all mem_* payload cleared; mem_valid=0; hilo_o=0; cnt_o=0. bubble_cnt unchanged. Overrides any stall.
  2. BUBBLE (stall[EX_IDX]==1 && stall[MEM_IDX]==0):
     - mem_* payload cleared, mem_valid=0.
     - hilo_o<=hilo_i and cnt_o<=cnt_i, so EX can iterate a multi-cycle op while stalled.
     - bubble_cnt+=1, saturating at all-ones; no wrap.
  3. HOLD (stall[EX_IDX]==1 && stall[MEM_IDX]==1): every output keeps its value.
  4. ADVANCE (stall[EX_IDX]==0):
     - mem_*<=ex_*; mem_valid<=ex_valid.
     - hilo_o<=0, cnt_o<=0 (multi-cycle op completed or absent).
- stall[EX_IDX]==0 with stall[MEM_IDX]==1 is illegal (ctrl stalls contiguously from IF). Treat it as HOLD; a simulation-only assertion fires.
- Payload is captured verbatim, including when ex_valid==0. Downstream consumers must gate on write enables.
- No arithmetic except bubble_cnt (unsigned, saturating).

Decomposition:
- Shared defines/package holds:
  - ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, RstEnable (1'b0)
  - stall index constants (EX/MEM) used by ctrl and all stage registers
- One sub-module is natural: sat_counter (PERF_W, inc, value), reusable by the other stage registers' perf counters.
- Payload registers stay inline.

Test Plan:
- Reset mid-stream:
  - Stimulus: rst=0 asserted between edges while mem_wdata=0x1234.
  - Required: all outputs 0 before the next edge; after rst=1, first edge captures ex_*.
- Advance:
  - Stimulus: stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0xDEADBEEF, ex_whilo=1, ex_hi=1, ex_lo=2.
  - Required: next cycle mem_* equal these values, mem_valid=1, hilo_o=0, cnt_o=0.
- Multi-cycle bubble:
  - Stimulus: stall=6'b001111 for 2 cycles, cnt_i=1 then 2, hilo_i=0xA..A.
  - Required: mem_wreg=0 and mem_valid=0; cnt_o follows 1 then 2; hilo_o=0xA..A; bubble_cnt=2.
  - Then stall=0: data advances, cnt_o=0.
- Hold:
  - Stimulus: stall=6'b011111 with changing ex_*.
  - Required: all outputs frozen, bubble_cnt unchanged.
- Flush priority:
  - Stimulus: flush=1 together with stall=6'b001111, cnt_i=3.
  - Required: mem_*=0, cnt_o=0, hilo_o=0, bubble_cnt unchanged.
- Saturation/illegal:
  - Stimulus: preload bubble_cnt to 0xFFFF via bubbles, then one more bubble.
  - Required: bubble_cnt stays 0xFFFF.
  - Stimulus: stall=6'b010000.
  - Required: outputs held, assertion fires.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Constants and mode decode shared by ctrl and the pipeline stage registers.
package ex_mem_stage_pkg;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        RST_ENABLE    = 1'b0;

    localparam int STALL_EX_IDX  = 3;
    localparam int STALL_MEM_IDX = 4;

    typedef enum logic [1:0] {
        MODE_ADVANCE = 2'd0,
        MODE_BUBBLE  = 2'd1,
        MODE_HOLD    = 2'd2,
        MODE_FLUSH   = 2'd3
    } stage_mode_e;

    // Flush beats any stall. The illegal "MEM stalled, EX not" pattern folds into hold.
    function automatic stage_mode_e decode_mode(input logic flush,
                                                input logic ex_stall,
                                                input logic mem_stall);
        if (flush)
            return MODE_FLUSH;
        else if (ex_stall && !mem_stall)
            return MODE_BUBBLE;
        else if (ex_stall || mem_stall)
            return MODE_HOLD;
        else
            return MODE_ADVANCE;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Stage payload bundle: the same shape carries EX outputs and MEM inputs.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              valid;
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output valid, wd, wreg, wdata, whilo, hi, lo);
    modport slave  (input  valid, wd, wreg, wdata, whilo, hi, lo);
endinterface

// File: rtl/ex_mem_stage_sat_counter.sv
// Unsigned up-counter that sticks at all-ones; used for stage perf counters.
module ex_mem_stage_sat_counter
    import ex_mem_stage_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE)
            value <= '0;
        else if (inc && (value != {W{1'b1}}))
            value <= value + 1'b1;
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush/bubble handling, multi-cycle carry-back
// and a saturating bubble counter.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6,
    parameter int EX_IDX  = STALL_EX_IDX,
    parameter int MEM_IDX = STALL_MEM_IDX,
    parameter int PERF_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    ex_mem_stage_if.slave       ex,
    ex_mem_stage_if.master      mem,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [PERF_W-1:0]   bubble_cnt
);

    stage_mode_e       mode;
    logic              valid_q;
    logic [REG_AW-1:0] wd_q;
    logic              wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              whilo_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // Only the EX and MEM bits matter here; the rest of the vector is for other stages.
    logic unused_stall;
    assign unused_stall = ^stall;

    always_comb begin
        mode = decode_mode(flush, stall[EX_IDX], stall[MEM_IDX]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= WRITE_DISABLE;
            wdata_q <= '0;
            whilo_q <= WRITE_DISABLE;
            hi_q    <= '0;
            lo_q    <= '0;
            hilo_o  <= '0;
            cnt_o   <= '0;
        end else begin
            case (mode)
                MODE_ADVANCE: begin
                    valid_q <= ex.valid;
                    wd_q    <= ex.wd;
                    wreg_q  <= ex.wreg;
                    wdata_q <= ex.wdata;
                    whilo_q <= ex.whilo;
                    hi_q    <= ex.hi;
                    lo_q    <= ex.lo;
                    hilo_o  <= '0;
                    cnt_o   <= '0;
                end
                MODE_BUBBLE, MODE_FLUSH: begin
                    valid_q <= 1'b0;
                    wd_q    <= '0;
                    wreg_q  <= WRITE_DISABLE;
                    wdata_q <= '0;
                    whilo_q <= WRITE_DISABLE;
                    hi_q    <= '0;
                    lo_q    <= '0;
                    // A bubble lets EX keep iterating its multi-cycle op; a flush abandons it.
                    hilo_o  <= (mode == MODE_BUBBLE) ? hilo_i : '0;
                    cnt_o   <= (mode == MODE_BUBBLE) ? cnt_i  : '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem.valid = valid_q;
    assign mem.wd    = wd_q;
    assign mem.wreg  = wreg_q;
    assign mem.wdata = wdata_q;
    assign mem.whilo = whilo_q;
    assign mem.hi    = hi_q;
    assign mem.lo    = lo_q;

    ex_mem_stage_sat_counter #(.W(PERF_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mode == MODE_BUBBLE),
        .value (bubble_cnt)
    );

    illegal_stall_a: assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
        !(stall[MEM_IDX] && !stall[EX_IDX]))
        else $warning("ex_mem_stage: non-contiguous stall vector %b treated as hold", stall);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed checks of ex_mem_stage against a behavioural model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    logic [15:0] bubble_cnt;

    int n_vec = 0;
    int n_err = 0;

    ex_mem_stage_if #(.DATA_W(32), .REG_AW(5)) ex_bus ();
    ex_mem_stage_if #(.DATA_W(32), .REG_AW(5)) mem_bus ();

    ex_mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .ex         (ex_bus.slave),
        .mem        (mem_bus.master),
        .hilo_i     (hilo_i),
        .cnt_i      (cnt_i),
        .hilo_o     (hilo_o),
        .cnt_o      (cnt_o),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: what the MEM side must show after each edge.
    logic        m_valid = 0, m_wreg = 0, m_whilo = 0;
    logic [4:0]  m_wd = 0;
    logic [31:0] m_wdata = 0, m_hi = 0, m_lo = 0;
    logic [63:0] m_hilo = 0;
    logic [1:0]  m_cnt = 0;
    logic [15:0] m_bc = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst || flush || (stall[3] && !stall[4])) begin
            m_valid <= 0; m_wd <= 0; m_wreg <= 0; m_wdata <= 0;
            m_whilo <= 0; m_hi <= 0; m_lo <= 0;
            if (!rst || flush) begin
                m_hilo <= 0; m_cnt <= 0;
            end else begin
                m_hilo <= hilo_i; m_cnt <= cnt_i;
            end
            if (!rst) m_bc <= 0;
            else if (!flush && m_bc != 16'hFFFF) m_bc <= m_bc + 16'd1;
        end else if (!stall[3] && !stall[4]) begin
            m_valid <= ex_bus.valid; m_wd <= ex_bus.wd; m_wreg <= ex_bus.wreg;
            m_wdata <= ex_bus.wdata; m_whilo <= ex_bus.whilo;
            m_hi <= ex_bus.hi; m_lo <= ex_bus.lo;
            m_hilo <= 0; m_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("valid", 64'(mem_bus.valid), 64'(m_valid));
        chk("wd", 64'(mem_bus.wd), 64'(m_wd));
        chk("wreg", 64'(mem_bus.wreg), 64'(m_wreg));
        chk("wdata", 64'(mem_bus.wdata), 64'(m_wdata));
        chk("whilo", 64'(mem_bus.whilo), 64'(m_whilo));
        chk("hi", 64'(mem_bus.hi), 64'(m_hi));
        chk("lo", 64'(mem_bus.lo), 64'(m_lo));
        chk("hilo_o", hilo_o, m_hilo);
        chk("cnt_o", 64'(cnt_o), 64'(m_cnt));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bc));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] wd, input logic w,
                          input logic [31:0] wdata, input logic wh,
                          input logic [31:0] hi, input logic [31:0] lo);
        ex_bus.valid = v; ex_bus.wd = wd; ex_bus.wreg = w; ex_bus.wdata = wdata;
        ex_bus.whilo = wh; ex_bus.hi = hi; ex_bus.lo = lo;
    endtask

    task automatic rand_ex();
        set_ex(1'($urandom), 5'($urandom), 1'($urandom), $urandom, 1'($urandom),
               $urandom, $urandom);
        hilo_i = {$urandom, $urandom};
        cnt_i  = 2'($urandom);
    endtask

    logic [5:0] stall_pick [7];

    initial begin
        stall_pick = '{6'b000000, 6'b000001, 6'b000111, 6'b001111,
                       6'b011111, 6'b111111, 6'b001111};
        rst = 1'b0; stall = 0; flush = 0; hilo_i = 0; cnt_i = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset valid", 64'(mem_bus.valid), 64'd0);
        chk("reset bubble_cnt", 64'(bubble_cnt), 64'd0);
        step(); step();
        rst = 1'b1;

        // Advance
        set_ex(1, 5'd5, 1, 32'hDEADBEEF, 1, 32'd1, 32'd2);
        hilo_i = 64'h1234_5678_9ABC_DEF0; cnt_i = 2'd3;
        step();
        chk("adv wd", 64'(mem_bus.wd), 64'd5);
        chk("adv wdata", 64'(mem_bus.wdata), 64'hDEADBEEF);
        chk("adv hi/lo", {mem_bus.hi, mem_bus.lo}, {32'd1, 32'd2});
        chk("adv flags", 64'({mem_bus.valid, mem_bus.wreg, mem_bus.whilo}), 64'b111);
        chk("adv carry", {hilo_o[61:0], cnt_o}, 64'd0);

        // Multi-cycle bubble
        stall = 6'b001111; hilo_i = {16{4'hA}}; cnt_i = 2'd1;
        step();
        chk("bub1 cnt_o", 64'(cnt_o), 64'd1);
        chk("bub1 hilo_o", hilo_o, {16{4'hA}});
        chk("bub1 valid/wreg", 64'({mem_bus.valid, mem_bus.wreg}), 64'd0);
        cnt_i = 2'd2;
        step();
        chk("bub2 cnt_o", 64'(cnt_o), 64'd2);
        chk("bub2 bubble_cnt", 64'(bubble_cnt), 64'd2);
        stall = 0; set_ex(1, 5'd7, 1, 32'h11223344, 0, 0, 0);
        step();
        chk("post-bubble wdata", 64'(mem_bus.wdata), 64'h11223344);
        chk("post-bubble cnt_o", 64'(cnt_o), 64'd0);

        // Hold
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            step();
            chk("hold wdata", 64'(mem_bus.wdata), 64'h11223344);
            chk("hold wd", 64'(mem_bus.wd), 64'd7);
            chk("hold bubble_cnt", 64'(bubble_cnt), 64'd2);
        end

        // Flush beats bubble
        stall = 6'b001111; flush = 1; cnt_i = 2'd3; hilo_i = 64'hFFFF_0000_FFFF_0000;
        step();
        chk("flush wdata", 64'(mem_bus.wdata), 64'd0);
        chk("flush carry", {hilo_o[61:0], cnt_o}, 64'd0);
        chk("flush bubble_cnt", 64'(bubble_cnt), 64'd2);
        flush = 0;

        // Reset mid-stream
        stall = 0; set_ex(1, 5'd9, 1, 32'h1234, 0, 0, 0);
        step();
        chk("pre-reset wdata", 64'(mem_bus.wdata), 64'h1234);
        #1 rst = 1'b0;
        #1;
        chk("async reset wdata", 64'(mem_bus.wdata), 64'd0);
        chk("async reset wd/valid", 64'({mem_bus.wd, mem_bus.valid}), 64'd0);
        chk("async reset bubble_cnt", 64'(bubble_cnt), 64'd0);
        #1 rst = 1'b1;
        set_ex(1, 5'd3, 1, 32'h5678, 0, 0, 0);
        step();
        chk("first capture wdata", 64'(mem_bus.wdata), 64'h5678);
        chk("first capture valid", 64'(mem_bus.valid), 64'd1);

        // Random legal traffic
        for (int i = 0; i < 1500; i++) begin
            stall = stall_pick[$urandom_range(0, 6)];
            flush = ($urandom_range(0, 15) == 0);
            rand_ex();
            step();
        end
        flush = 0;

        // Illegal stall pattern behaves as hold
        stall = 0; set_ex(1, 5'd12, 1, 32'hCAFEF00D, 1, 32'h55, 32'h66);
        step();
        stall = 6'b010000; rand_ex();
        step();
        chk("illegal wdata", 64'(mem_bus.wdata), 64'hCAFEF00D);
        chk("illegal hi", 64'(mem_bus.hi), 64'h55);
        stall = 0;
        step();

        // Saturation
        stall = 6'b001111;
        for (int i = 0; i < 70000 && m_bc != 16'hFFFF; i++) begin
            rand_ex();
            step();
        end
        chk("saturate reach", 64'(bubble_cnt), 64'hFFFF);
        rand_ex();
        step();
        chk("saturate hold", 64'(bubble_cnt), 64'hFFFF);
        stall = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
